// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian WALK/DON'T WALK controller slaved to the traffic light state
// Optional chirp output enabled by defining PED_CHIRP_EN.
module ped_crossing_ctrl #(
    parameter int WALK_CYC  = 8,
    parameter int CLEAR_CYC = 6,
    parameter int FLASH_DIV = 2,
    parameter int CW        = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    state_in,
    input  logic          ped_btn,
    output logic          walk,
    output logic          dont_walk,
    output logic          ped_wait,
    output logic [CW-1:0] countdown,
    output logic          err,
    output logic          chirp
);

    localparam logic [3:0] S_OFF    = 4'b0001;
    localparam logic [3:0] S_RED    = 4'b0010;
    localparam logic [3:0] S_YELLOW = 4'b0100;
    localparam logic [3:0] S_GREEN  = 4'b1000;

    localparam int            FW         = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [CW-1:0] WALK_LD    = CW'(WALK_CYC);
    localparam logic [CW-1:0] CLEAR_LD   = CW'(CLEAR_CYC);
    localparam logic [CW-1:0] CD_ONE     = CW'(1);

    typedef enum logic [1:0] {P_OFF, P_DONT, P_WALK, P_CLEAR} pstate_t;

    pstate_t       st;
    logic          req;
    logic          btn_q;
    logic          red_q;
    logic          flash_ph;
    logic [FW-1:0] flash_cnt;

    logic legal, is_red, to_off, press, red_rise;

    assign legal    = (state_in == S_OFF) || (state_in == S_RED) ||
                      (state_in == S_YELLOW) || (state_in == S_GREEN);
    assign is_red   = (state_in == S_RED);
    // Illegal codes behave exactly like OFF.
    assign to_off   = !legal || (state_in == S_OFF);
    assign press    = ped_btn && !btn_q;
    assign red_rise = is_red && !red_q;
    assign ped_wait = req;

`ifdef PED_CHIRP_EN
    logic [1:0] chirp_cnt;
`else
    assign chirp = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= P_OFF;
            req       <= 1'b0;
            btn_q     <= 1'b0;
            red_q     <= 1'b0;
            flash_ph  <= 1'b0;
            flash_cnt <= '0;
            walk      <= 1'b0;
            dont_walk <= 1'b0;
            countdown <= '0;
            err       <= 1'b0;
`ifdef PED_CHIRP_EN
            chirp     <= 1'b0;
            chirp_cnt <= '0;
`endif
        end else begin
            btn_q <= ped_btn;
            red_q <= is_red;
            err   <= !legal;
`ifdef PED_CHIRP_EN
            chirp <= 1'b0;
`endif
            case (st)
                P_OFF: begin
                    req       <= 1'b0;
                    walk      <= 1'b0;
                    dont_walk <= 1'b0;
                    countdown <= '0;
                    if (!to_off) begin
                        st        <= P_DONT;
                        dont_walk <= 1'b1;
                    end
                end
                P_DONT: begin
                    if (to_off) begin
                        st        <= P_OFF;
                        req       <= 1'b0;
                        walk      <= 1'b0;
                        dont_walk <= 1'b0;
                        countdown <= '0;
                    end else if (red_rise && req) begin
                        st        <= P_WALK;
                        req       <= 1'b0;
                        walk      <= 1'b1;
                        dont_walk <= 1'b0;
                        countdown <= WALK_LD;
`ifdef PED_CHIRP_EN
                        chirp     <= 1'b1;
                        chirp_cnt <= 2'd1;
`endif
                    end else if (press) begin
                        req <= 1'b1;
                    end
                end
                P_WALK, P_CLEAR: begin
                    if (!is_red) begin
                        walk      <= 1'b0;
                        countdown <= '0;
                        st        <= to_off ? P_OFF : P_DONT;
                        dont_walk <= !to_off;
                    end else if (st == P_WALK) begin
                        if (countdown == CD_ONE) begin
                            st        <= P_CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= CLEAR_LD;
                            flash_ph  <= 1'b1;
                            flash_cnt <= '0;
                        end else begin
                            countdown <= countdown - CD_ONE;
`ifdef PED_CHIRP_EN
                            chirp     <= (chirp_cnt == 2'd0);
                            chirp_cnt <= chirp_cnt + 2'd1;
`endif
                        end
                    end else if (countdown == CD_ONE) begin
                        st        <= P_DONT;
                        dont_walk <= 1'b1;
                        countdown <= '0;
                    end else begin
                        countdown <= countdown - CD_ONE;
                        // dont_walk shows the phase the flasher holds after this edge.
                        if (flash_cnt == FLASH_LAST) begin
                            flash_cnt <= '0;
                            flash_ph  <= !flash_ph;
                            dont_walk <= !flash_ph;
                        end else begin
                            flash_cnt <= flash_cnt + FW'(1);
                            dont_walk <= flash_ph;
                        end
                    end
                end
                default: st <= P_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl
module tb_ped_crossing_ctrl;

    localparam logic [3:0] OFF = 4'b0001;
    localparam logic [3:0] RED = 4'b0010;
    localparam logic [3:0] YEL = 4'b0100;
    localparam logic [3:0] GRN = 4'b1000;

`ifdef PED_CHIRP_EN
    localparam bit CHIRP_ON = 1'b1;
`else
    localparam bit CHIRP_ON = 1'b0;
`endif

    typedef struct packed {
        logic       w;
        logic       dw;
        logic       pw;
        logic [3:0] cd;
        logic       e;
        logic       ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state_in;
    logic       ped_btn;
    logic       walk, dont_walk, ped_wait, err, chirp;
    logic [3:0] countdown;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_n  = 0;

    logic [0:5] flash_pat = 6'b110011;
    logic [0:7] walk_btn  = 8'b11110100;

    ped_crossing_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .state_in  (state_in),
        .ped_btn   (ped_btn),
        .walk      (walk),
        .dont_walk (dont_walk),
        .ped_wait  (ped_wait),
        .countdown (countdown),
        .err       (err),
        .chirp     (chirp)
    );

    always #5 clk = ~clk;

    task automatic vec(input logic r, input logic [3:0] s, input logic b,
                       input logic w, input logic dw, input logic pw,
                       input int cd, input logic e, input logic ch);
        exp_t x;
        @(negedge clk);
        reset    = r;
        state_in = s;
        ped_btn  = b;
        x.w  = w;
        x.dw = dw;
        x.pw = pw;
        x.cd = cd[3:0];
        x.e  = e;
        x.ch = ch & CHIRP_ON;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (walk && dont_walk) begin
            errors++;
            $display("FAIL lamp_exclusive t=%0t walk=%b dont_walk=%b required not both 1", $time, walk, dont_walk);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({walk, dont_walk, ped_wait, countdown, err, chirp} !== e) begin
                errors++;
                $display("FAIL vec%0d got w=%b dw=%b pw=%b cd=%0d err=%b ch=%b want w=%b dw=%b pw=%b cd=%0d err=%b ch=%b",
                         mon_n, walk, dont_walk, ped_wait, countdown, err, chirp,
                         e.w, e.dw, e.pw, e.cd, e.e, e.ch);
            end
            mon_n++;
        end
    end

    initial begin
        reset    = 1'b0;
        state_in = OFF;
        ped_btn  = 1'b0;

        // reset, then GREEN brings up solid DON'T WALK
        vec(0, OFF, 0, 0,0,0,0,0,0);
        vec(0, OFF, 0, 0,0,0,0,0,0);
        vec(1, GRN, 0, 0,1,0,0,0,0);
        vec(1, GRN, 0, 0,1,0,0,0,0);

        // full walk + flashing clearance
        vec(1, GRN, 1, 0,1,1,0,0,0);
        vec(1, GRN, 0, 0,1,1,0,0,0);
        vec(1, YEL, 0, 0,1,1,0,0,0);
        vec(1, YEL, 0, 0,1,1,0,0,0);
        for (int i = 0; i < 8; i++) vec(1, RED, 0, 1,0,0,8-i,0,(i%4)==0);
        for (int i = 0; i < 6; i++) vec(1, RED, 0, 0,flash_pat[i],0,6-i,0,0);
        repeat (6) vec(1, RED, 0, 0,1,0,0,0,0);

        // presses during WALK ignored; press mid-RED waits for next entry
        vec(1, GRN, 0, 0,1,0,0,0,0);
        vec(1, GRN, 1, 0,1,1,0,0,0);
        for (int i = 0; i < 8; i++) vec(1, RED, walk_btn[i], 1,0,0,8-i,0,(i%4)==0);
        for (int i = 0; i < 6; i++) vec(1, RED, 0, 0,flash_pat[i],0,6-i,0,0);
        vec(1, RED, 0, 0,1,0,0,0,0);
        vec(1, RED, 1, 0,1,1,0,0,0);
        repeat (3) vec(1, RED, 0, 0,1,1,0,0,0);

        // short RED aborts the walk without clearance
        vec(1, GRN, 0, 0,1,1,0,0,0);
        for (int i = 0; i < 3; i++) vec(1, RED, 0, 1,0,0,8-i,0,i==0);
        repeat (3) vec(1, GRN, 0, 0,1,0,0,0,0);

        // illegal codes
        vec(1, GRN, 1, 0,1,1,0,0,0);
        vec(1, GRN, 0, 0,1,1,0,0,0);
        vec(1, RED, 0, 1,0,0,8,0,1);
        vec(1, RED, 0, 1,0,0,7,0,0);
        vec(1, 4'b0110, 0, 0,0,0,0,1,0);
        vec(1, GRN, 0, 0,1,0,0,0,0);
        vec(1, GRN, 0, 0,1,0,0,0,0);
        vec(1, 4'b0000, 0, 0,0,0,0,1,0);
        vec(1, OFF, 0, 0,0,0,0,0,0);
        vec(1, YEL, 0, 0,1,0,0,0,0);

        // press coinciding with RED entry is served next RED
        vec(1, RED, 1, 0,1,1,0,0,0);
        vec(1, RED, 0, 0,1,1,0,0,0);
        vec(1, GRN, 0, 0,1,1,0,0,0);
        vec(1, RED, 0, 1,0,0,8,0,1);
        vec(1, RED, 0, 1,0,0,7,0,0);
        vec(1, GRN, 0, 0,1,0,0,0,0);

        // asynchronous reset mid-WALK
        vec(1, GRN, 1, 0,1,1,0,0,0);
        vec(1, GRN, 0, 0,1,1,0,0,0);
        vec(1, RED, 0, 1,0,0,8,0,1);
        vec(1, RED, 0, 1,0,0,7,0,0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({walk, dont_walk, ped_wait, countdown, err, chirp} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset got w=%b dw=%b pw=%b cd=%0d err=%b ch=%b want all 0",
                     walk, dont_walk, ped_wait, countdown, err, chirp);
        end
        vec(0, RED, 0, 0,0,0,0,0,0);
        vec(1, OFF, 0, 0,0,0,0,0,0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
